sop_truth_capture: RTL
======================

// Module: sop_truth_capture
// PURPOSE
//  Sequential sweep-and-check harness for the 4-input SOP function blocks (a,b,c,d -> y).
//  Drives all 16 input vectors (a=MSB, d=LSB) into the downstream SOP block and samples its y.
//  Assembles the sampled values into a 16-bit truth table and compares each bit against an
//  expected minterm mask. Used on-board/in-sim as the stage that feeds and consumes the SOP block.
// PARAMETERS
//  SETTLE_CYCLES  1         cycles vector is held before y is sampled (0..15 legal; 0 = no settle state)
//  EXPECTED       16'hE01A  expected truth table, bit i = y for abcd==i (default = minterms 1,3,4,13,14,15)
// PORTS
//  clk           in   1   single clock, all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  start         in   1   request a sweep; accepted only in IDLE
//  a_o,b_o,c_o,d_o out 1  vector driven to SOP block = idx[3],idx[2],idx[1],idx[0]
//  y_i           in   1   SOP block output
//  busy          out  1   high from accepted start until DONE state left
//  done          out  1   one-cycle pulse when sweep completes
//  pass          out  1   1 iff last completed sweep had zero mismatches; held until next start
//  table_o       out  16  captured truth table, bit i written when vector i sampled
//  mismatch_cnt  out  5   count of bits where y_i != EXPECTED[i] (0..16)
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, all outputs 0 (a_o..d_o=0, busy=0, done=0, pass=0, table_o=0, cnt=0).
//  - FSM IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//    IDLE: start=1 -> idx<=0, table_o<=0, mismatch_cnt<=0, pass<=0, settle_cnt<=SETTLE_CYCLES;
//          next = SETTLE (or SAMPLE directly if SETTLE_CYCLES==0).
//    SETTLE: holds vector; decrements settle_cnt; at 1 -> SAMPLE. Exactly SETTLE_CYCLES cycles.
//    SAMPLE: one cycle; table_o[idx]<=y_i; if y_i!=EXPECTED[idx] mismatch_cnt<=+1.
//          idx==15 -> DONE; else idx<=idx+1, reload settle_cnt, -> SETTLE (or SAMPLE if 0).
//    DONE: done=1 for exactly this cycle; pass<=(final mismatch_cnt==0); -> IDLE.
//  - a_o..d_o are registered from idx; vector i stable for the whole SETTLE+SAMPLE window.
//  - Latency: DONE cycle begins 16*(SETTLE_CYCLES+1) cycles after the start-accepting edge.
//  - busy=1 in SETTLE, SAMPLE, DONE; 0 in IDLE.
//  - start while busy (incl. DONE cycle) ignored; no queuing. start held high -> new sweep
//    begins the cycle after DONE (IDLE accepts it).
//  - idx never wraps: 15 is terminal. mismatch_cnt saturates naturally at 16 (5 bits, no overflow).
//  - rst mid-sweep wins over everything: immediate return to reset values next edge, no done pulse.
//  - table_o, mismatch_cnt, pass remain readable in IDLE until next accepted start.
// CONFIGURATION
//  Macro SOP_CAP_ERRLOG_EN:
//   defined: extra outputs err_valid(1) and first_err_idx(4); on first mismatch in a sweep
//            err_valid<=1, first_err_idx<=idx; later mismatches do not overwrite; both cleared
//            on reset and on accepted start.
//   undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared include sop_cap_pkg.vh: state encodings (S_IDLE,S_SETTLE,S_SAMPLE,S_DONE, 2 bits),
//    TT_W=16, IDX_W=4, CNT_W=5, default expected mask SOP_EXP_MASK=16'hE01A.
//  - One sub-module: sop_settle_timer (load/decrement counter, 'expire' output) used by SETTLE.
//  - Top holds FSM, idx register, capture/compare datapath.
// TESTING
//  1. SOP block with minterms 1,3,4,13,14,15 on y_i, SETTLE=1, start pulse -> done at +32 cycles,
//     table_o=16'hE01A, mismatch_cnt=0, pass=1, busy low cycle after done.
//  2. y_i tied 0 -> table_o=16'h0000, mismatch_cnt=6, pass=0.
//  3. y_i tied 1 -> table_o=16'hFFFF, mismatch_cnt=10, pass=0.
//  4. rst asserted in SAMPLE with idx=7 -> next cycle all outputs 0, no done; fresh start -> full
//     16-vector sweep, result as test 1.
//  5. start pulsed at idx=5 and during DONE -> ignored (single done pulse); SETTLE=0 -> done at +16.
//  6. SOP_CAP_ERRLOG_EN, y_i = EXPECTED with bit 4 and bit 13 flipped -> err_valid=1,
//     first_err_idx=4, mismatch_cnt=2.

Source files
------------

// File: rtl/sop_truth_capture_pkg.sv
// Shared definitions for the SOP truth-table capture harness: FSM state
// encoding, datapath widths and the default expected minterm mask.
package sop_truth_capture_pkg;

   localparam int TT_W  = 16;
   localparam int IDX_W = 4;
   localparam int CNT_W = 5;

   // Minterms 1,3,4,13,14,15 of the reference 4-input SOP block
   localparam logic [TT_W-1:0] SOP_EXP_MASK = 16'hE01A;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } cap_state_t;

   // True when the sweep index points at the final input vector
   function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
      return idx == {IDX_W{1'b1}};
   endfunction

endpackage

// File: rtl/sop_truth_capture_if.sv
// Signal bundle between the capture harness and its environment.
// Optional macro SOP_CAP_ERRLOG_EN adds err_valid / first_err_idx.
interface sop_truth_capture_if;
   import sop_truth_capture_pkg::*;

   logic             start;
   logic             a_o;
   logic             b_o;
   logic             c_o;
   logic             d_o;
   logic             y_i;
   logic             busy;
   logic             done;
   logic             pass;
   logic [TT_W-1:0]  table_o;
   logic [CNT_W-1:0] mismatch_cnt;
`ifdef SOP_CAP_ERRLOG_EN
   logic             err_valid;
   logic [IDX_W-1:0] first_err_idx;
`endif

   // Environment side: requests sweeps, feeds back the SOP block output
   modport master (
      output start,
      output y_i,
      input  a_o, b_o, c_o, d_o,
      input  busy, done, pass, table_o, mismatch_cnt
`ifdef SOP_CAP_ERRLOG_EN
      , input err_valid, first_err_idx
`endif
   );

   // Harness side
   modport slave (
      input  start,
      input  y_i,
      output a_o, b_o, c_o, d_o,
      output busy, done, pass, table_o, mismatch_cnt
`ifdef SOP_CAP_ERRLOG_EN
      , output err_valid, first_err_idx
`endif
   );

endinterface

// File: rtl/sop_truth_capture_settle_timer.sv
// Load/decrement counter that times how long each vector is held before
// sampling. 'expire' flags the last settle cycle (count equals one).
module sop_truth_capture_settle_timer
   import sop_truth_capture_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [IDX_W-1:0] load_val,
   output logic             expire
);

   logic [IDX_W-1:0] cnt;

   // Reload at the start of every vector, count down while settling
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = (cnt == IDX_W'(1));

endmodule

// File: rtl/sop_truth_capture.sv
// Sweep-and-check harness: drives all 16 abcd vectors into a downstream
// SOP block, captures y into a truth table and counts mismatches against
// EXPECTED. Optional macro SOP_CAP_ERRLOG_EN records the first failing index.
module sop_truth_capture
   import sop_truth_capture_pkg::*;
#(
   parameter int unsigned     SETTLE_CYCLES = 1,
   parameter logic [TT_W-1:0] EXPECTED      = SOP_EXP_MASK
)
(
   input  logic                 clk,
   input  logic                 rst,
   sop_truth_capture_if.slave   bus
);

   localparam logic [IDX_W-1:0] SETTLE_LOAD = IDX_W'(SETTLE_CYCLES);
   localparam bit               HAS_SETTLE  = (SETTLE_CYCLES != 0);

   cap_state_t       state;
   cap_state_t       state_next;
   logic [IDX_W-1:0] idx;
   logic [TT_W-1:0]  table_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pass_q;

   logic             start_accept;
   logic             sample_en;
   logic             finish;
   logic             timer_load;
   logic             timer_dec;
   logic             timer_expire;
   logic             mismatch_now;

   sop_truth_capture_settle_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .dec      (timer_dec),
      .load_val (SETTLE_LOAD),
      .expire   (timer_expire)
   );

   // State register; reset wins over everything, including a pending done
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and per-state datapath strobes
   always_comb begin
      state_next   = state;
      start_accept = 1'b0;
      sample_en    = 1'b0;
      finish       = 1'b0;
      timer_load   = 1'b0;
      timer_dec    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               start_accept = 1'b1;
               timer_load   = 1'b1;
               state_next   = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
            end
         end
         S_SETTLE: begin
            timer_dec = 1'b1;
            if (timer_expire) begin
               state_next = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            sample_en = 1'b1;
            if (is_last_idx(idx)) begin
               state_next = S_DONE;
            end else begin
               timer_load = 1'b1;
               state_next = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
            end
         end
         S_DONE: begin
            finish     = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign mismatch_now = (bus.y_i != EXPECTED[idx]);

   // Sweep index, truth-table capture, mismatch count and final verdict
   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         table_q <= '0;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else if (start_accept) begin
         idx     <= '0;
         table_q <= '0;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         if (sample_en) begin
            table_q[idx] <= bus.y_i;
            if (mismatch_now) begin
               cnt_q <= cnt_q + 1'b1;
            end
            if (!is_last_idx(idx)) begin
               idx <= idx + 1'b1;
            end
         end
         if (finish) begin
            pass_q <= (cnt_q == '0);
         end
      end
   end

`ifdef SOP_CAP_ERRLOG_EN
   logic             err_valid_q;
   logic [IDX_W-1:0] first_err_q;

   // Latch the index of the first mismatch seen in the current sweep
   always_ff @(posedge clk) begin
      if (rst || start_accept) begin
         err_valid_q <= 1'b0;
         first_err_q <= '0;
      end else if (sample_en && mismatch_now && !err_valid_q) begin
         err_valid_q <= 1'b1;
         first_err_q <= idx;
      end
   end

   assign bus.err_valid     = err_valid_q;
   assign bus.first_err_idx = first_err_q;
`endif

   assign bus.a_o          = idx[3];
   assign bus.b_o          = idx[2];
   assign bus.c_o          = idx[1];
   assign bus.d_o          = idx[0];
   assign bus.busy         = (state != S_IDLE);
   assign bus.done         = (state == S_DONE);
   assign bus.pass         = pass_q;
   assign bus.table_o      = table_q;
   assign bus.mismatch_cnt = cnt_q;

endmodule
